fetch_pc_unit: RTL and testbench

Instruction-fetch stage of the RV32I pipeline, directly upstream of the branch target buffer. It owns the PC register and selects the next PC from sequential fetch, the BTB prediction or an ID-stage redirect. It holds the IF/ID pipeline register, which carries each fetched instruction's prediction forward, and detects mispredictions when branches resolve in ID. It also drives the BTB's update input and keeps saturating hit/miss counters.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_pc_unit_sat_counter.sv | 23 ++
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 tb/tb_fetch_pc_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR        : canonical RV32I NOP (addi x0, x0, 0), used for bubbles
//   DEFAULT_RESET_PC : default fetch address after reset
//   ifid_t           : IF/ID pipeline payload
//   ifid_bubble()    : IF/ID contents representing an empty slot
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        predicted;
        logic [31:0] pred_target;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.pc          = '0;
        b.instr       = NOP_INSTR;
        b.valid       = 1'b0;
        b.predicted   = 1'b0;
        b.pred_target = '0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential, BTB
// prediction, or ID-stage redirect), IF/ID pipeline register, misprediction
// detection, BTB update direction and hit/miss statistics.
//   clk, rst                  : clock, asynchronous active-high reset
//   stall                     : hazard hold, freezes PC and IF/ID
//   imem_rdata                : instruction at pc (combinational memory)
//   btb_predicted/_address    : BTB prediction for pc
//   id_is_branch/taken/target : branch resolution for the instruction in ID
//   pc                        : current fetch PC
//   ifid_*                    : IF/ID payload (pc, instr, valid, prediction)
//   mispredict                : combinational flush/redirect request
//   btb_update_taken          : resolved-taken indication towards the BTB
//   hit_count, miss_count     : saturating prediction statistics
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [31:0]          imem_rdata,
    input  logic                 btb_predicted,
    input  logic [31:0]          btb_predicted_address,
    input  logic                 id_is_branch,
    input  logic                 id_taken,
    input  logic [31:0]          id_target,
    output logic [31:0]          pc,
    output logic [31:0]          ifid_pc,
    output logic [31:0]          ifid_instr,
    output logic                 ifid_valid,
    output logic                 ifid_predicted,
    output logic [31:0]          ifid_pred_target,
    output logic                 mispredict,
    output logic                 btb_update_taken,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    ifid_t       ifid_q;
    ifid_t       fetched;
    logic [31:0] next_pc;
    logic        resolve;
    logic        actual;
    logic [31:0] correct_pc;

    // IF stage: prediction-driven next PC and the payload captured into IF/ID
    assign next_pc = btb_predicted ? {btb_predicted_address[31:2], 2'b00}
                                   : pc + 32'd4;

    always_comb begin
        fetched.pc          = pc;
        fetched.instr       = imem_rdata;
        fetched.valid       = 1'b1;
        fetched.predicted   = btb_predicted;
        fetched.pred_target = btb_predicted_address;
    end

    // ID stage: resolution is gated by stall so a held branch is retried later.
    // A prediction on a non-branch is wrong too and falls back to ifid_pc + 4.
    assign resolve    = ifid_q.valid & ~stall;
    assign actual     = id_is_branch & id_taken;
    assign correct_pc = actual ? id_target : ifid_q.pc + 32'd4;
    assign mispredict = resolve &
                        ((actual != ifid_q.predicted) |
                         (actual & ifid_q.predicted & (id_target != ifid_q.pred_target)));
    assign btb_update_taken = resolve & actual;

    // IF/ID boundary: redirect squashes the wrong-path fetch with a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            ifid_q <= ifid_bubble();
        end else if (mispredict) begin
            pc     <= {correct_pc[31:2], 2'b00};
            ifid_q <= ifid_bubble();
        end else if (!stall) begin
            pc     <= next_pc;
            ifid_q <= fetched;
        end
    end

    assign ifid_pc          = ifid_q.pc;
    assign ifid_instr       = ifid_q.instr;
    assign ifid_valid       = ifid_q.valid;
    assign ifid_predicted   = ifid_q.predicted;
    assign ifid_pred_target = ifid_q.pred_target;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolve & id_is_branch & ~mispredict),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (miss_count)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] imem_rdata;
    logic        btb_predicted;
    logic [31:0] btb_predicted_address;
    logic        id_is_branch;
    logic        id_taken;
    logic [31:0] id_target;

    logic [31:0] pc, ifid_pc, ifid_instr, ifid_pred_target;
    logic        ifid_valid, ifid_predicted, mispredict, btb_update_taken;
    logic [31:0] hit_count, miss_count;

    logic [31:0] pc2, ifid_pc2, ifid_instr2, ifid_pred_target2;
    logic        ifid_valid2, ifid_predicted2, mispredict2, btb_update_taken2;
    logic [1:0]  hit_count2, miss_count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h100), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .imem_rdata(imem_rdata),
        .btb_predicted(btb_predicted), .btb_predicted_address(btb_predicted_address),
        .id_is_branch(id_is_branch), .id_taken(id_taken), .id_target(id_target),
        .pc(pc), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
        .ifid_predicted(ifid_predicted), .ifid_pred_target(ifid_pred_target),
        .mispredict(mispredict), .btb_update_taken(btb_update_taken),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    // Same stimulus, 2-bit counters: exercises saturation
    fetch_pc_unit #(.RESET_PC(32'h100), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .imem_rdata(imem_rdata),
        .btb_predicted(btb_predicted), .btb_predicted_address(btb_predicted_address),
        .id_is_branch(id_is_branch), .id_taken(id_taken), .id_target(id_target),
        .pc(pc2), .ifid_pc(ifid_pc2), .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2),
        .ifid_predicted(ifid_predicted2), .ifid_pred_target(ifid_pred_target2),
        .mispredict(mispredict2), .btb_update_taken(btb_update_taken2),
        .hit_count(hit_count2), .miss_count(miss_count2)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_ipc, m_instr, m_ptgt;
    logic        m_v, m_pred;
    longint      m_hit, m_miss;
    logic [31:0] n_pc, n_ipc, n_instr, n_ptgt;
    logic        n_v, n_pred;
    longint      n_hit, n_miss;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[31:2] ^ 30'h1234567, 2'b11};
    endfunction

    function automatic logic [31:0] sat2(input longint v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    task automatic model_reset();
        m_pc = 32'h100; m_ipc = 32'h0; m_instr = 32'h13; m_ptgt = 32'h0;
        m_v = 1'b0; m_pred = 1'b0; m_hit = 0; m_miss = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic bp, input logic [31:0] bpa,
                         input logic ib, input logic it, input logic [31:0] itg);
        stall = st; btb_predicted = bp; btb_predicted_address = bpa;
        id_is_branch = ib; id_taken = it; id_target = itg;
        imem_rdata = imem_f(m_pc);
        #1;
    endtask

    // Compares DUT against the model for the current cycle and works out the
    // model's state after the coming edge.
    task automatic check_model(input string tag);
        logic taken_now, res, wrong;
        logic [31:0] true_next;
        res       = m_v && !stall;
        taken_now = id_is_branch && id_taken;
        wrong     = 1'b0;
        if (res) begin
            if (taken_now != m_pred)                        wrong = 1'b1;
            else if (taken_now && (id_target != m_ptgt))    wrong = 1'b1;
        end
        true_next = taken_now ? id_target : (m_ipc + 32'd4);

        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc2"}, pc2, m_pc);
        chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
        chk({tag, ".ifid_instr"}, ifid_instr, m_instr);
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_v});
        chk({tag, ".ifid_valid2"}, {31'b0, ifid_valid2}, {31'b0, m_v});
        chk({tag, ".ifid_pred"}, {31'b0, ifid_predicted}, {31'b0, m_pred});
        chk({tag, ".ifid_ptgt"}, ifid_pred_target, m_ptgt);
        chk({tag, ".mispredict"}, {31'b0, mispredict}, {31'b0, wrong});
        chk({tag, ".btb_upd"}, {31'b0, btb_update_taken}, {31'b0, res && taken_now});
        chk({tag, ".hit"}, hit_count, 32'(m_hit));
        chk({tag, ".miss"}, miss_count, 32'(m_miss));
        chk({tag, ".hit2"}, {30'b0, hit_count2}, sat2(m_hit));
        chk({tag, ".miss2"}, {30'b0, miss_count2}, sat2(m_miss));

        n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr; n_v = m_v;
        n_pred = m_pred; n_ptgt = m_ptgt; n_hit = m_hit; n_miss = m_miss;
        if (wrong) begin
            n_pc = {true_next[31:2], 2'b00};
            n_ipc = 32'h0; n_instr = 32'h13; n_v = 1'b0; n_pred = 1'b0; n_ptgt = 32'h0;
            n_miss = m_miss + 1;
        end else if (!stall) begin
            n_ipc = m_pc; n_instr = imem_rdata; n_v = 1'b1;
            n_pred = btb_predicted; n_ptgt = btb_predicted_address;
            n_pc = btb_predicted ? {btb_predicted_address[31:2], 2'b00} : m_pc + 32'd4;
        end
        if (res && id_is_branch && !wrong) n_hit = m_hit + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr; m_v = n_v;
        m_pred = n_pred; m_ptgt = n_ptgt; m_hit = n_hit; m_miss = n_miss;
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".pc"}, pc, 32'h100);
        chk({tag, ".ifid_pc"}, ifid_pc, 32'h0);
        chk({tag, ".ifid_instr"}, ifid_instr, 32'h13);
        chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, 32'h0);
        chk({tag, ".ifid_pred"}, {31'b0, ifid_predicted}, 32'h0);
        chk({tag, ".ifid_ptgt"}, ifid_pred_target, 32'h0);
        chk({tag, ".mispredict"}, {31'b0, mispredict}, 32'h0);
        chk({tag, ".btb_upd"}, {31'b0, btb_update_taken}, 32'h0);
        chk({tag, ".hit"}, hit_count, 32'h0);
        chk({tag, ".miss"}, miss_count, 32'h0);
        chk({tag, ".miss2"}, {30'b0, miss_count2}, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        st, bp;
        logic [31:0] bpa;
        logic        ib, it;
        logic [31:0] itg;
        logic [31:0] e_pc, e_ipc;
        logic        e_v, e_mp, e_upd;
        logic [31:0] e_hit, e_miss;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, input logic bp, input logic [31:0] bpa,
                       input logic ib, input logic it, input logic [31:0] itg,
                       input logic [31:0] e_pc, input logic [31:0] e_ipc,
                       input logic e_v, input logic e_mp, input logic e_upd,
                       input logic [31:0] e_hit, input logic [31:0] e_miss);
        vec_t v;
        v.st = st; v.bp = bp; v.bpa = bpa; v.ib = ib; v.it = it; v.itg = itg;
        v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_v = e_v; v.e_mp = e_mp; v.e_upd = e_upd;
        v.e_hit = e_hit; v.e_miss = e_miss;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        r_st, r_bp, r_ib, r_it;
        logic [31:0] r_bpa, r_itg;

        //   st    bp    bpa            ib    it    itg            pc             ifid_pc        v     mp    upd   hit    miss
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h100,       32'h0,         1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h104,       32'h100,       1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h108,       32'h104,       1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        add(1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h10C,       32'h108,       1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h200,       32'h10C,       1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        add(1'b0, 1'b1, 32'h200,      1'b0, 1'b0, 32'h0,        32'h204,       32'h200,       1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h200,       32'h204,       1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h999,      32'h208,       32'h0,         1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300,      32'h20C,       32'h208,       1'b1, 1'b1, 1'b1, 32'd1, 32'd1);
        add(1'b0, 1'b1, 32'h400,      1'b0, 1'b0, 32'h0,        32'h300,       32'h0,         1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h440,      32'h400,       32'h300,       1'b1, 1'b1, 1'b1, 32'd1, 32'd2);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h440,       32'h0,         1'b0, 1'b0, 1'b0, 32'd1, 32'd3);
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h500,      32'h444,       32'h440,       1'b1, 1'b0, 1'b0, 32'd1, 32'd3);
        add(1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h500,      32'h444,       32'h440,       1'b1, 1'b0, 1'b0, 32'd1, 32'd3);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h500,      32'h444,       32'h440,       1'b1, 1'b1, 1'b1, 32'd1, 32'd3);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h500,       32'h0,         1'b0, 1'b0, 1'b0, 32'd1, 32'd4);
        add(1'b0, 1'b1, 32'h603,      1'b0, 1'b0, 32'h0,        32'h504,       32'h500,       1'b1, 1'b0, 1'b0, 32'd1, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h600,       32'h504,       1'b1, 1'b1, 1'b0, 32'd1, 32'd4);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h508,       32'h0,         1'b0, 1'b0, 1'b0, 32'd1, 32'd5);
        add(1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h50C,       32'h508,       1'b1, 1'b0, 1'b0, 32'd1, 32'd5);
        add(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h510,       32'h50C,       1'b1, 1'b0, 1'b0, 32'd2, 32'd5);

        // Reset state; ID inputs claim a taken branch, which must be ignored
        rst = 1'b1;
        stall = 1'b0; btb_predicted = 1'b0; btb_predicted_address = 32'h0;
        id_is_branch = 1'b1; id_taken = 1'b1; id_target = 32'h7F0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        model_reset();

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].st, tbl[i].bp, tbl[i].bpa, tbl[i].ib, tbl[i].it, tbl[i].itg);
            chk({t, ".pc"}, pc, tbl[i].e_pc);
            chk({t, ".ifid_pc"}, ifid_pc, tbl[i].e_ipc);
            chk({t, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, tbl[i].e_v});
            chk({t, ".mispredict"}, {31'b0, mispredict}, {31'b0, tbl[i].e_mp});
            chk({t, ".btb_upd"}, {31'b0, btb_update_taken}, {31'b0, tbl[i].e_upd});
            chk({t, ".hit"}, hit_count, tbl[i].e_hit);
            chk({t, ".miss"}, miss_count, tbl[i].e_miss);
            chk({t, ".miss2"}, {30'b0, miss_count2}, (tbl[i].e_miss > 32'd3) ? 32'd3 : tbl[i].e_miss);
            check_model(t);
            tick();
        end

        // Wrap-around of the predicted path and of the redirect address
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        check_model("wrap_a"); tick();
        chk("wrap_a.pc_top", pc, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check_model("wrap_b"); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_c.mispredict", {31'b0, mispredict}, 32'h1);
        check_model("wrap_c"); tick();
        chk("wrap_c.pc_redirect", pc, 32'h0);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        check_model("wrap_d"); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check_model("wrap_e"); tick();
        chk("wrap_e.pc_seq", pc, 32'h0);

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            r_st  = ($urandom_range(0, 4) == 0);
            r_bp  = ($urandom_range(0, 2) == 0);
            r_bpa = $urandom() & 32'h0000_0FFF;
            if ($urandom_range(0, 2) == 0) begin
                r_ib = 1'b1; r_it = m_pred; r_itg = m_ptgt;
            end else begin
                r_ib  = 1'($urandom_range(0, 1));
                r_it  = 1'($urandom_range(0, 1));
                r_itg = $urandom() & 32'h0000_0FFC;
            end
            drive(r_st, r_bp, r_bpa, r_ib, r_it, r_itg);
            check_model($sformatf("rand%0d", i));
            tick();
        end

        // Asynchronous reset mid-cycle, then restart from RESET_PC
        drive(1'b0, 1'b1, 32'h880, 1'b1, 1'b1, 32'h884);
        #2;
        rst = 1'b1;
        #1;
        check_reset("midreset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_model("post_reset0"); tick();
        chk("post_reset.ifid_pc", ifid_pc, 32'h100);
        chk("post_reset.pc", pc, 32'h104);
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, ($urandom_range(0, 3) == 0), $urandom() & 32'hFFC,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom() & 32'hFFC);
            check_model($sformatf("post%0d", i));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
